hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Drives hold/flush inputs of PC and IF/ID, ID/EX, EX/MEM pipeline regs (hold=1 keeps value, flush=1 zeroes).
//  Detects load-use hazards in ID, flushes wrong-path instrs on taken branch/jump resolved in EX,
//  stalls front end for multi-cycle mul/div occupying EX. Sits beside datapath, between decode/EX ctrl and regs.
// PARAMETERS
//  MD_LATENCY  4   total stall cycles per mul/div op, legal range 2..16
//  CNT_W       32  width of perf counters (only with HAZ_PERF_CNT_EN)
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      reset, synchronous, active-low
//  id_rs          in   5      rs field of instr in ID
//  id_rt          in   5      rt field of instr in ID
//  id_uses_rt     in   1      ID instr reads rt as source
//  ex_mem_read    in   1      EX instr is a load
//  ex_rt          in   5      destination rt of EX load
//  ex_redirect    in   1      taken branch/jump resolved in EX this cycle
//  md_start       in   1      mul/div in EX, first cycle
//  pc_hold        out  1      PC write inhibit
//  if_id_hold     out  1      IF/ID write inhibit
//  if_id_flush    out  1      IF/ID clear
//  id_ex_hold     out  1      ID/EX write inhibit
//  id_ex_flush    out  1      ID/EX clear (bubble)
//  ex_mem_flush   out  1      EX/MEM clear (bubble)
//  md_done        out  1      last stall cycle of mul/div
//  stall_cnt      out  CNT_W  cycles with pc_hold=1 (0 unless HAZ_PERF_CNT_EN)
//  flush_cnt      out  CNT_W  ex_redirect events (0 unless HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  Outputs combinational from state + inputs; regs sample them same edge. State/counters registered.
//  rst_n=0 at edge: state<=RUN, md_cnt<=0, perf counters<=0. While rst_n=0 all outputs forced 0.
//  FSM RUN / MD_WAIT. md_cnt is 4-bit down counter.
//  RUN priority, highest first:
//   1 ex_redirect: if_id_flush=1, id_ex_flush=1, no holds; md_start ignored; stay RUN.
//   2 md_start: pc_hold=if_id_hold=id_ex_hold=1, ex_mem_flush=1; next MD_WAIT, md_cnt<=MD_LATENCY-2.
//   3 load-use: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)):
//     pc_hold=if_id_hold=1, id_ex_flush=1; exactly one bubble; stay RUN.
//   4 else all outputs 0.
//  MD_WAIT: pc_hold=if_id_hold=id_ex_hold=1, ex_mem_flush=1 every cycle; ex_redirect, md_start,
//   load-use ignored. md_cnt==0: md_done=1, next RUN; else md_cnt<=md_cnt-1.
//  Mul/div stall = exactly MD_LATENCY cycles (1 in RUN + MD_LATENCY-1 in MD_WAIT).
//  Load-use pending after MD_WAIT re-evaluated in RUN normally.
//  Register r0 never causes hazard. Hold and flush never both 1 on same register.
//  Reset mid-MD_WAIT: abandon op, RUN next cycle, no md_done.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt +1 each cycle pc_hold=1; flush_cnt +1 each RUN cycle with
//   ex_redirect=1; both saturate at all-ones, no wrap.
//  Not defined: counters not instantiated, stall_cnt/flush_cnt tied 0.
// STRUCTURE
//  hazard_ctrl_pkg: state encoding (RUN=1'b0, MD_WAIT=1'b1), MD_CNT_W=4, REG_ZERO=5'd0.
//  Sub-module hazard_perf_counter (saturating CNT_W counter, inc + sync clear), x2 under macro.
// TESTING
//  1 ex_mem_read=1, ex_rt=8, id_rs=8 -> 1 cycle pc_hold=if_id_hold=id_ex_flush=1, then all 0.
//  2 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; ex_rt=9=id_rt, id_uses_rt=0 -> no stall.
//  3 md_start 1 cycle, MD_LATENCY=4 -> pc_hold high 4 cycles, md_done only in 4th, RUN after.
//  4 ex_redirect + load-use same cycle -> if_id_flush=id_ex_flush=1, pc_hold=0.
//  5 ex_redirect during MD_WAIT -> ignored, stall length unchanged; rst_n=0 mid-wait -> outputs 0, RUN.
//  6 HAZ_PERF_CNT_EN, CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated); undefined -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard control unit.
//            FSM state encoding, mul/div countdown width and the hardwired
//            zero register index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Pipeline control FSM: normal issue vs. waiting on a multi-cycle mul/div.
  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Width of the mul/div remaining-cycle down counter (covers MD_LATENCY<=16).
  localparam int MD_CNT_W = 4;

  // Register r0 is hardwired to zero and can never carry a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Bundles the decode/EX status lines feeding the hazard unit and
//            the hold/flush controls it returns to the pipeline registers.
// Ports    : none (interface); modports:
//            master - datapath side: drives ID/EX status, receives controls
//            slave  - hazard unit side: receives status, drives controls
//            Status : id_rs[5], id_rt[5], id_uses_rt, ex_mem_read, ex_rt[5],
//                     ex_redirect, md_start
//            Control: pc_hold, if_id_hold, if_id_flush, id_ex_hold,
//                     id_ex_flush, ex_mem_flush, md_done,
//                     stall_cnt[CNT_W], flush_cnt[CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  // Decode / execute status
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_redirect;
  logic             md_start;

  // Pipeline register controls
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_hold;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_done;

  // Performance counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, md_start,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_flush, md_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, md_start,
    output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_flush, md_done, stall_cnt, flush_cnt
  );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : hazard_perf_counter
// Purpose  : Saturating event counter with synchronous clear. Counts up by
//            one per cycle with i_inc=1 and sticks at all-ones.
// Ports    : clk            in  clock, rising edge
//            i_clr          in  synchronous clear (wins over i_inc)
//            i_inc          in  count enable
//            o_cnt[CNT_W]   out current count
// Revision : 1.0 - initial release
// ============================================================================
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             i_clr,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : hazard_perf_counter
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Purpose  : Generates hold/flush controls for PC, IF/ID, ID/EX and EX/MEM.
//            Handles load-use stalls detected in ID, wrong-path flushes on a
//            taken branch/jump resolved in EX, and front-end stalls while a
//            multi-cycle mul/div occupies EX.
// Ports    : clk          in  clock, rising edge
//            rst_n        in  synchronous active-low reset (outputs forced 0
//                             while low)
//            bus          hazard_ctrl_if.slave (status in, controls out)
// Params   : MD_LATENCY   total stall cycles per mul/div op (2..16)
//            CNT_W        performance counter width
// Config   : HAZ_PERF_CNT_EN - when defined, stall_cnt/flush_cnt are live
//            saturating counters; otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  hazard_ctrl_if.slave bus
);

  // First cycle of the op is spent in RUN, so MD_WAIT counts MD_LATENCY-1
  // cycles: load MD_LATENCY-2 and finish on the cycle the counter reads 0.
  localparam logic [MD_CNT_W-1:0] C_MD_INIT = MD_CNT_W'(MD_LATENCY - 2);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;

  logic w_load_use;
  logic w_pc_hold;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_hold;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;
  logic w_md_done;

  // Load in EX writing a register that the ID instruction reads.
  assign w_load_use = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_md_cnt_nxt   = r_md_cnt;
    w_pc_hold      = 1'b0;
    w_if_id_hold   = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_hold   = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_md_done      = 1'b0;

    // Under reset every control stays low; the state register reloads RUN.
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (bus.ex_redirect) begin
            // Kill the two wrong-path instructions behind the branch. No
            // hold, so a simultaneous md_start/load-use is dropped with them.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (bus.md_start) begin
            w_pc_hold      = 1'b1;
            w_if_id_hold   = 1'b1;
            w_id_ex_hold   = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_state_nxt    = MD_WAIT;
            w_md_cnt_nxt   = C_MD_INIT;
          end else if (w_load_use) begin
            // Freeze fetch/decode and inject one bubble into EX.
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_flush = 1'b1;
          end
        end

        MD_WAIT: begin
          w_pc_hold      = 1'b1;
          w_if_id_hold   = 1'b1;
          w_id_ex_hold   = 1'b1;
          w_ex_mem_flush = 1'b1;
          if (r_md_cnt == '0) begin
            w_md_done   = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
          end
        end

        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign bus.pc_hold      = w_pc_hold;
  assign bus.if_id_hold   = w_if_id_hold;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_hold   = w_id_ex_hold;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.md_done      = w_md_done;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  logic w_cnt_clr;
  logic w_redirect_evt;

  assign w_cnt_clr      = !rst_n;
  // Only redirects acted upon in RUN count; those masked by MD_WAIT do not.
  assign w_redirect_evt = rst_n && (r_state == RUN) && bus.ex_redirect;

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_inc (w_pc_hold),
    .o_cnt (bus.stall_cnt)
  );

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_inc (w_redirect_evt),
    .o_cnt (bus.flush_cnt)
  );
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule : hazard_ctrl_unit
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Purpose  : Directed self-checking bench for hazard_ctrl_unit (MD_LATENCY=4,
//            CNT_W=2). Inputs change on the falling edge; outputs are checked
//            1 ns later, well away from the rising edge.
//            Output vector layout used in the checks:
//            {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
//             ex_mem_flush, md_done}
// Config   : HAZ_PERF_CNT_EN selects expected perf counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

  localparam logic [6:0] E_IDLE = 7'b000_0000;
  localparam logic [6:0] E_LU   = 7'b110_0100;
  localparam logic [6:0] E_MD   = 7'b110_1010;
  localparam logic [6:0] E_MDD  = 7'b110_1011;
  localparam logic [6:0] E_RDR  = 7'b001_0100;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  hazard_ctrl_if #(.CNT_W(2)) bus ();

  hazard_ctrl_unit #(
    .MD_LATENCY (4),
    .CNT_W      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] obs;
  assign obs = {bus.pc_hold, bus.if_id_hold, bus.if_id_flush, bus.id_ex_hold,
                bus.id_ex_flush, bus.ex_mem_flush, bus.md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge, settle 1 ns.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic mr,
                       input logic [4:0] ert, input logic redir,
                       input logic mds);
    @(negedge clk);
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rt  = uses_rt;
    bus.ex_mem_read = mr;
    bus.ex_rt       = ert;
    bus.ex_redirect = redir;
    bus.md_start    = mds;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Load-use and md_start asserted while in reset: everything stays low.
    rst_n = 1'b0;
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
    end
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    n_vec++;
    if ((obs !== E_IDLE) || (bus.stall_cnt !== 2'd0) || (bus.flush_cnt !== 2'd0)) begin
      n_err++;
      $display("FAIL reset_hold: got %b cnt %0d/%0d expected %b cnt 0/0",
               obs, bus.stall_cnt, bus.flush_cnt, E_IDLE);
    end
    rst_n = 1'b1;
    idle();
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL reset_release: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_load_use();
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_LU) begin
      n_err++;
      $display("FAIL load_use_rs: got %b expected %b", obs, E_LU);
    end
    // Load has moved on; instruction in ID proceeds.
    idle();
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL load_use_after: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_no_hazard();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL r0_no_hazard: got %b expected %b", obs, E_IDLE);
    end
    drive(5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL rt_unused: got %b expected %b", obs, E_IDLE);
    end
    drive(5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_LU) begin
      n_err++;
      $display("FAIL rt_used: got %b expected %b", obs, E_LU);
    end
    drive(5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL not_load: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_muldiv();
    logic [6:0] exp_seq [4] = '{E_MD, E_MD, E_MD, E_MDD};
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle();
      n_vec++;
      if (obs !== exp_seq[i]) begin
        n_err++;
        $display("FAIL muldiv_cycle%0d: got %b expected %b", i, obs, exp_seq[i]);
      end
    end
    idle();
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL muldiv_exit: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_redirect_priority();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
    n_vec++;
    if (obs !== E_RDR) begin
      n_err++;
      $display("FAIL redirect_priority: got %b expected %b", obs, E_RDR);
    end
    idle();
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL redirect_stays_run: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_md_masking();
    logic [6:0] exp_seq [4] = '{E_MD, E_MD, E_MD, E_MDD};
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    n_vec++;
    if (obs !== exp_seq[0]) begin
      n_err++;
      $display("FAIL mask_cycle0: got %b expected %b", obs, exp_seq[0]);
    end
    // Redirect, a second md_start and a load-use all ignored in MD_WAIT.
    for (int i = 1; i < 4; i++) begin
      drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
      n_vec++;
      if (obs !== exp_seq[i]) begin
        n_err++;
        $display("FAIL mask_cycle%0d: got %b expected %b", i, obs, exp_seq[i]);
      end
    end
    // Pending load-use is evaluated normally once back in RUN.
    drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    n_vec++;
    if (obs !== E_LU) begin
      n_err++;
      $display("FAIL mask_pending_lu: got %b expected %b", obs, E_LU);
    end
    idle();
  endtask

  task automatic test_md_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    n_vec++;
    if (obs !== E_MD) begin
      n_err++;
      $display("FAIL mdrst_waiting: got %b expected %b", obs, E_MD);
    end
    rst_n = 1'b0;
    idle();
    n_vec++;
    if (obs !== E_IDLE) begin
      n_err++;
      $display("FAIL mdrst_forced0: got %b expected %b", obs, E_IDLE);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_vec++;
      if (obs !== E_IDLE) begin
        n_err++;
        $display("FAIL mdrst_abandon%0d: got %b expected %b", i, obs, E_IDLE);
      end
    end
  endtask

  task automatic test_perf();
    logic [1:0] exp_stall2;
    logic [1:0] exp_stall5;
    logic [1:0] exp_flush;
`ifdef HAZ_PERF_CNT_EN
    exp_stall2 = 2'd2;
    exp_stall5 = 2'd3;
    exp_flush  = 2'd1;
`else
    exp_stall2 = 2'd0;
    exp_stall5 = 2'd0;
    exp_flush  = 2'd0;
`endif
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    // 1 load-use stall + 4 mul/div stalls = 5 stall cycles.
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    n_vec++;
    if (bus.stall_cnt !== exp_stall2) begin
      n_err++;
      $display("FAIL stall_cnt_mid: got %0d expected %0d", bus.stall_cnt, exp_stall2);
    end
    // Redirect inside MD_WAIT does not count.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    n_vec++;
    if (bus.stall_cnt !== exp_stall5) begin
      n_err++;
      $display("FAIL stall_cnt_sat: got %0d expected %0d", bus.stall_cnt, exp_stall5);
    end
    n_vec++;
    if (bus.flush_cnt !== exp_flush) begin
      n_err++;
      $display("FAIL flush_cnt: got %0d expected %0d", bus.flush_cnt, exp_flush);
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_uses_rt  = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = '0;
    bus.ex_redirect = 1'b0;
    bus.md_start    = 1'b0;
    repeat (2) @(posedge clk);

    test_reset();
    test_load_use();
    test_no_hazard();
    test_muldiv();
    test_redirect_priority();
    test_md_masking();
    test_md_reset();
    test_perf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit
`default_nettype wire
